// File: rtl/aes_pkg.sv
// Shared AES definitions: byte width, ShiftRows offsets and the row-shift byte permutation.
// Supports Rijndael block widths Nb = 4, 6 and 8.
package aes_pkg;

    localparam int AES_BYTE_W = 8;
    localparam int AES_MAX_NB = 8;
    localparam int AES_MAX_W  = 4 * AES_BYTE_W * AES_MAX_NB;

    // Rijndael Nb=8 moves rows 2 and 3 one column further than Nb=4/6.
    function automatic int shift_amt(input int nb, input int row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    function automatic logic [AES_MAX_W-1:0] shift_rows_perm(
        input logic [AES_MAX_W-1:0] st,
        input int                   nb,
        input logic                 inv
    );
        logic [AES_MAX_W-1:0] res;
        int                   src;
        res = '0;
        for (int c = 0; c < AES_MAX_NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (c < nb) begin
                    src = inv ? (c + nb - shift_amt(nb, r)) % nb
                              : (c + shift_amt(nb, r)) % nb;
                    res[AES_BYTE_W*(4*c+r) +: AES_BYTE_W] = st[AES_BYTE_W*(4*src+r) +: AES_BYTE_W];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// Single valid/ready register slice holding one beat of W payload bits.
// Latency 1 cycle; up_rdy_o is combinational from dn_rdy_i so a full chain streams at one beat per cycle.
// Backpressure: holds its beat stable while dn_rdy_i is low.
module aes_pipe_stage #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_vld_i,
    output logic         up_rdy_o,
    input  logic [W-1:0] up_dat_i,
    output logic         dn_vld_o,
    input  logic         dn_rdy_i,
    output logic [W-1:0] dn_dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    // Empty, or the held beat leaves this cycle.
    assign up_rdy_o = !vld_q | dn_rdy_i;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (up_rdy_o) begin
            vld_d = up_vld_i;
            if (up_vld_i) begin
                dat_d = up_dat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dn_vld_o = vld_q;
    assign dn_dat_o = dat_q;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// ShiftRows / InvShiftRows (per-beat in_inv) followed by a chain of STAGES register slices carrying {tag, state}.
// Latency STAGES-1 cycles after the accept edge; full throughput; in_ready is combinational through the chain.
// Backpressure: out_* hold while out_ready is low; in_ready falls once every slice is occupied.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [32*NB-1:0]  out_state
);

    localparam int DW = 32 * NB;
    localparam int PW = TAG_W + DW;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
        $error("aes_shift_rows_pipe: TAG_W must be 1..16");
    end

    logic [AES_MAX_W-1:0] perm_full;
    logic [DW-1:0]        perm;

    always_comb begin
        perm_full = shift_rows_perm(AES_MAX_W'(in_state), NB, in_inv);
    end
    assign perm = perm_full[DW-1:0];

    if (DW < AES_MAX_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = &{1'b0, perm_full[AES_MAX_W-1:DW]};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic          up_vld, dn_rdy, vld, rdy;
        logic [PW-1:0] up_dat, dat;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = {in_tag, perm};
        end else begin : g_link
            assign up_vld = g_stg[k-1].vld;
            assign up_dat = g_stg[k-1].dat;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_next
            assign dn_rdy = g_stg[k+1].rdy;
        end

        aes_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_vld_i (up_vld),
            .up_rdy_o (rdy),
            .up_dat_i (up_dat),
            .dn_vld_o (vld),
            .dn_rdy_i (dn_rdy),
            .dn_dat_o (dat)
        );
    end

    assign in_ready  = g_stg[0].rdy;
    assign out_valid = g_stg[STAGES-1].vld;
    assign out_tag   = g_stg[STAGES-1].dat[PW-1:DW];
    assign out_state = g_stg[STAGES-1].dat[DW-1:0];

    a_no_x_out: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !$isunknown(out_state));

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe across NB=4/6/8 and STAGES=1/2/3 instances.
module tb_aes_shift_rows_pipe;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: NB=4 STAGES=1   b: NB=4 STAGES=3   c: NB=8 STAGES=2   d: NB=6 STAGES=1
    logic a_iv = 0, a_ir, a_inv = 0, a_ov, a_or = 1;
    logic [3:0] a_it = 0, a_ot;
    logic [127:0] a_is = 0, a_os;
    logic b_iv = 0, b_ir, b_inv = 0, b_ov, b_or = 1;
    logic [3:0] b_it = 0, b_ot;
    logic [127:0] b_is = 0, b_os;
    logic c_iv = 0, c_ir, c_inv = 0, c_ov, c_or = 1;
    logic [3:0] c_it = 0, c_ot;
    logic [255:0] c_is = 0, c_os;
    logic d_iv = 0, d_ir, d_inv = 0, d_ov, d_or = 1;
    logic [3:0] d_it = 0, d_ot;
    logic [191:0] d_is = 0, d_os;

    aes_shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_inv(a_inv),
        .in_tag(a_it), .in_state(a_is), .out_valid(a_ov), .out_ready(a_or),
        .out_tag(a_ot), .out_state(a_os));
    aes_shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_inv(b_inv),
        .in_tag(b_it), .in_state(b_is), .out_valid(b_ov), .out_ready(b_or),
        .out_tag(b_ot), .out_state(b_os));
    aes_shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_inv(c_inv),
        .in_tag(c_it), .in_state(c_is), .out_valid(c_ov), .out_ready(c_or),
        .out_tag(c_ot), .out_state(c_os));
    aes_shift_rows_pipe #(.NB(6), .STAGES(1), .TAG_W(4)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in_inv(d_inv),
        .in_tag(d_it), .in_state(d_is), .out_valid(d_ov), .out_ready(d_or),
        .out_tag(d_ot), .out_state(d_os));

    // Reference: out byte (r,c) takes in byte (r, c +/- s(r) mod nb).
    function automatic logic [255:0] ref_perm(input logic [255:0] st, input int nb, input bit inv);
        logic [255:0] o;
        int r, c, s, src;
        o = '0;
        for (int i = 0; i < 4 * nb; i++) begin
            r = i % 4;
            c = i / 4;
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            src = inv ? (c + nb - s) % nb : (c + s) % nb;
            o[8*i +: 8] = st[8*(4*src + r) +: 8];
        end
        return o;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] X1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] E1 = 128'h0b06010c_07020d08_030e0904_0f0a0500;
    localparam logic [127:0] E2 = 128'h0306090c_0f020508_0b0e0104_070a0d00;

    logic [127:0] bexp [24];
    logic [3:0]   btag [24];
    logic [255:0] tmp, v8, e8;
    logic [127:0] held;

    initial begin
        // Reset state
        #2;
        chk("rst_a_ov", a_ov, 1'b0);
        chk("rst_a_ir", a_ir, 1'b1);
        chk("rst_a_os", a_os, 128'h0);
        chk("rst_a_ot", a_ot, 4'h0);
        chk("rst_b_ov", b_ov, 1'b0);
        chk("rst_c_os", c_os, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1/2: NB=4 forward, inverse, and inverse of forward
        a_iv = 1; a_inv = 0; a_is = X1; a_it = 4'h1;
        chk("a_ir_idle", a_ir, 1'b1);
        @(negedge clk);
        chk("fwd_ov", a_ov, 1'b1);
        chk("fwd_state", a_os, E1);
        chk("fwd_tag", a_ot, 4'h1);
        a_inv = 1; a_it = 4'h2;
        @(negedge clk);
        chk("inv_state", a_os, E2);
        chk("inv_tag", a_ot, 4'h2);
        a_is = E1; a_it = 4'h3;
        @(negedge clk);
        chk("roundtrip", a_os, X1);
        chk("roundtrip_tag", a_ot, 4'h3);
        a_iv = 0;
        @(negedge clk);
        chk("a_drained", a_ov, 1'b0);

        // 3: STAGES=3, 20 back-to-back beats, alternating mode
        for (int n = 0; n < 24; n++) begin
            if (n >= 3 && n - 3 < 20) begin
                chk("stream_ov", b_ov, 1'b1);
                chk("stream_state", b_os, bexp[n-3]);
                chk("stream_tag", b_ot, btag[n-3]);
            end else begin
                chk("stream_idle", b_ov, 1'b0);
            end
            chk("stream_ir", b_ir, 1'b1);
            if (n < 20) begin
                tmp = rnd256();
                b_iv = 1; b_is = tmp[127:0]; b_inv = n[0]; b_it = n[3:0];
                tmp = ref_perm({128'h0, b_is}, 4, b_inv);
                bexp[n] = tmp[127:0];
                btag[n] = b_it;
            end else begin
                b_iv = 0;
            end
            @(negedge clk);
        end

        // 4: backpressure with pipeline full
        b_or = 0;
        for (int n = 0; n < 4; n++) begin
            tmp = rnd256();
            b_is = tmp[127:0]; b_inv = n[0]; b_it = 4'(n + 8);
            tmp = ref_perm({128'h0, b_is}, 4, b_inv);
            bexp[n] = tmp[127:0];
            btag[n] = b_it;
            b_iv = 1;
            if (n < 3) @(negedge clk);
        end
        held = b_os;
        for (int n = 0; n < 5; n++) begin
            chk("bp_ir", b_ir, 1'b0);
            chk("bp_ov", b_ov, 1'b1);
            chk("bp_state", b_os, bexp[0]);
            chk("bp_stable", b_os, held);
            chk("bp_tag", b_ot, btag[0]);
            @(negedge clk);
        end
        b_or = 1;
        #1;
        chk("bp_release_ir", b_ir, 1'b1);
        @(negedge clk);
        b_iv = 0;
        for (int n = 1; n < 4; n++) begin
            chk("bp_drain_ov", b_ov, 1'b1);
            chk("bp_drain_state", b_os, bexp[n]);
            chk("bp_drain_tag", b_ot, btag[n]);
            @(negedge clk);
        end
        chk("bp_empty", b_ov, 1'b0);

        // 5: NB=8 identity pattern, then random NB=8 and NB=6 vectors
        for (int i = 0; i < 32; i++) v8[8*i +: 8] = 8'(i);
        c_iv = 1; c_inv = 0; c_is = v8; c_it = 4'h5;
        @(negedge clk);
        c_iv = 0;
        @(negedge clk);
        chk("nb8_ov", c_ov, 1'b1);
        chk("nb8_r3c0", c_os[31:24], 8'h13);
        chk("nb8_r2c0", c_os[23:16], 8'h0e);
        chk("nb8_tag", c_ot, 4'h5);
        for (int n = 0; n < 4; n++) begin
            c_iv = 1; c_is = rnd256(); c_inv = n[0]; c_it = 4'(n);
            e8 = ref_perm(c_is, 8, c_inv);
            @(negedge clk);
            c_iv = 0;
            @(negedge clk);
            chk("nb8_rand", c_os, e8);
        end
        for (int n = 0; n < 4; n++) begin
            tmp = rnd256();
            d_iv = 1; d_is = tmp[191:0]; d_inv = n[0]; d_it = 4'(n + 3);
            tmp = ref_perm({64'h0, d_is}, 6, d_inv);
            @(negedge clk);
            d_iv = 0;
            chk("nb6_rand", d_os, tmp[191:0]);
            chk("nb6_tag", d_ot, 4'(n + 3));
            @(negedge clk);
        end

        // 6: asynchronous reset with two beats in flight
        b_or = 0; b_iv = 1; b_inv = 0; b_is = X1; b_it = 4'hA;
        @(negedge clk);
        b_it = 4'hB;
        @(negedge clk);
        b_iv = 0;
        @(negedge clk);
        chk("pre_rst_ov", b_ov, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", b_ov, 1'b0);
        chk("arst_ir", b_ir, 1'b1);
        chk("arst_os", b_os, 128'h0);
        chk("arst_ot", b_ot, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        b_or = 1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("post_rst_quiet", b_ov, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
